// File: rtl/scheduler_acc_lookup.sv
// Task-type to accelerator-ID resolver: scans the scheduling table over port B, one entry per two cycles.
// Define SCHED_LOOKUP_RR_EN to rotate the returned ID across the matched type's instances.
module scheduler_acc_lookup #(
    parameter int MAX_ACCS        = 16,
    parameter int MAX_ACC_TYPES   = 16,
    parameter int SCHED_DATA_BITS = 48,
    localparam int ACC_BITS               = $clog2(MAX_ACCS),
    localparam int ACC_TYPE_BITS          = $clog2(MAX_ACC_TYPES),
    localparam int SCHED_DATA_COUNT_L     = 0,
    localparam int SCHED_DATA_ACCID_L     = ACC_BITS,
    localparam int SCHED_DATA_TASK_TYPE_L = 2 * ACC_BITS,
    localparam int SCHED_DATA_TASK_TYPE_H = SCHED_DATA_BITS - 1,
    localparam int SCHED_TASKTYPE_BITS    = SCHED_DATA_TASK_TYPE_H - SCHED_DATA_TASK_TYPE_L + 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ACC_TYPE_BITS:0]         num_acc_types,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [SCHED_TASKTYPE_BITS-1:0] req_task_type,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_hit,
    output logic [ACC_BITS-1:0]            resp_acc_id,
    output logic [ACC_BITS-1:0]            resp_first_id,
    output logic [ACC_BITS-1:0]            resp_count,
    output logic [ACC_TYPE_BITS-1:0]       scheduleData_portB_addr,
    output logic                           scheduleData_portB_en,
    input  logic [SCHED_DATA_BITS-1:0]     scheduleData_portB_dout
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // READ  | port B read of entry idx issued
    // CMP   | entry idx on dout, compared against the latched type
    // RESP  | result held on outputs until resp_ready
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CMP, ST_RESP} state_t;

    state_t                         state;
    logic [ACC_TYPE_BITS-1:0]       idx;
    logic [SCHED_TASKTYPE_BITS-1:0] task_type_q;

    logic [SCHED_TASKTYPE_BITS-1:0] dout_type;
    logic [ACC_BITS-1:0]            dout_accid;
    logic [ACC_BITS-1:0]            dout_count;
    logic [ACC_BITS-1:0]            sel_acc_id;
    logic [ACC_TYPE_BITS:0]         last_idx;
    logic                           is_last;

    assign dout_type  = scheduleData_portB_dout[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
    assign dout_accid = scheduleData_portB_dout[SCHED_DATA_ACCID_L +: ACC_BITS];
    assign dout_count = scheduleData_portB_dout[SCHED_DATA_COUNT_L +: ACC_BITS];
    assign last_idx   = num_acc_types - 1'b1;
    assign is_last    = ({1'b0, idx} == last_idx);

`ifdef SCHED_LOOKUP_RR_EN
    logic [ACC_BITS-1:0] rr [MAX_ACC_TYPES];

    assign sel_acc_id = dout_accid + rr[idx];

    // idx still points at the matched entry while in RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_ACC_TYPES; i++) rr[i] <= '0;
        end else if (state == ST_RESP && resp_ready && resp_hit) begin
            rr[idx] <= (rr[idx] == resp_count) ? '0 : rr[idx] + 1'b1;
        end
    end
`else
    assign sel_acc_id = dout_accid;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                   <= ST_IDLE;
            idx                     <= '0;
            task_type_q             <= '0;
            req_ready               <= 1'b1;
            resp_valid              <= 1'b0;
            resp_hit                <= 1'b0;
            resp_acc_id             <= '0;
            resp_first_id           <= '0;
            resp_count              <= '0;
            scheduleData_portB_addr <= '0;
            scheduleData_portB_en   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        task_type_q   <= req_task_type;
                        idx           <= '0;
                        req_ready     <= 1'b0;
                        resp_hit      <= 1'b0;
                        resp_acc_id   <= '0;
                        resp_first_id <= '0;
                        resp_count    <= '0;
                        if (num_acc_types == '0) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state                   <= ST_READ;
                            scheduleData_portB_en   <= 1'b1;
                            scheduleData_portB_addr <= '0;
                        end
                    end
                end
                ST_READ: begin
                    scheduleData_portB_en <= 1'b0;
                    state                 <= ST_CMP;
                end
                ST_CMP: begin
                    if (dout_type == task_type_q) begin
                        state         <= ST_RESP;
                        resp_valid    <= 1'b1;
                        resp_hit      <= 1'b1;
                        resp_acc_id   <= sel_acc_id;
                        resp_first_id <= dout_accid;
                        resp_count    <= dout_count;
                    end else if (is_last) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        idx                     <= idx + 1'b1;
                        scheduleData_portB_addr <= idx + 1'b1;
                        scheduleData_portB_en   <= 1'b1;
                        state                   <= ST_READ;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state         <= ST_IDLE;
                        resp_valid    <= 1'b0;
                        req_ready     <= 1'b1;
                        resp_hit      <= 1'b0;
                        resp_acc_id   <= '0;
                        resp_first_id <= '0;
                        resp_count    <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scheduler_acc_lookup.sv
// Bench for scheduler_acc_lookup: fixed-table vectors, reset/backpressure sequences, randomized lookups vs a scan model.
module tb_scheduler_acc_lookup;

    localparam int TT_BITS = 40;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [4:0]         num_acc_types;
    logic               req_valid;
    logic               req_ready;
    logic [TT_BITS-1:0] req_task_type;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_hit;
    logic [3:0]         resp_acc_id;
    logic [3:0]         resp_first_id;
    logic [3:0]         resp_count;
    logic [3:0]         portb_addr;
    logic               portb_en;
    logic [47:0]        portb_dout;

    logic [47:0] tbl [16];
    int          rr_m [16];
    int          n_vec = 0;
    int          n_err = 0;

    scheduler_acc_lookup dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .num_acc_types           (num_acc_types),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_task_type           (req_task_type),
        .resp_valid              (resp_valid),
        .resp_ready              (resp_ready),
        .resp_hit                (resp_hit),
        .resp_acc_id             (resp_acc_id),
        .resp_first_id           (resp_first_id),
        .resp_count              (resp_count),
        .scheduleData_portB_addr (portb_addr),
        .scheduleData_portB_en   (portb_en),
        .scheduleData_portB_dout (portb_dout)
    );

    always #5 clk = ~clk;

    // Table memory with one cycle of read latency
    always @(posedge clk) begin
        if (portb_en) portb_dout <= tbl[portb_addr];
    end

    function automatic logic [47:0] mk(input logic [TT_BITS-1:0] tt, input int acc, input int cnt);
        logic [3:0] a, c;
        a = 4'(acc);
        c = 4'(cnt);
        return {tt, a, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_and_check(input logic [TT_BITS-1:0] tt, input int hold, input bit early,
                                 input bit e_hit, input int e_first, input int e_cnt,
                                 input int e_acc, input int e_lat);
        int         lat;
        int         en_cnt;
        bit         busy_ready;
        bit         unstable;
        logic [3:0] c_acc, c_first, c_cnt;
        logic       c_hit;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid     = 1'b1;
        req_task_type = tt;
        @(negedge clk);
        req_valid     = 1'b0;
        req_task_type = TT_BITS'($urandom);
        lat = 1; en_cnt = 0; busy_ready = 0;
        while (resp_valid !== 1'b1 && lat < 200) begin
            if (portb_en) en_cnt++;
            if (req_ready) busy_ready = 1;
            @(negedge clk);
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            chk("resp_timeout", resp_valid, 1);
            return;
        end
        if (req_ready) busy_ready = 1;
        chk("latency", lat, e_lat);
        chk("portb_en_pulses", en_cnt, (e_lat - 1) / 2);
        chk("resp_hit", resp_hit, e_hit);
        chk("resp_acc_id", resp_acc_id, e_acc);
        chk("resp_first_id", resp_first_id, e_first);
        chk("resp_count", resp_count, e_cnt);
        c_acc = resp_acc_id; c_first = resp_first_id; c_cnt = resp_count; c_hit = resp_hit;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_hit !== c_hit ||
                resp_acc_id !== c_acc || resp_first_id !== c_first || resp_count !== c_cnt)
                unstable = 1;
        end
        chk("hold_stable", unstable, 0);
        chk("req_ready_busy", busy_ready, 0);
        resp_ready = 1'b1;
        if (early) begin
            req_valid     = 1'b1;
            req_task_type = tt;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("resp_valid_after", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    function automatic void model(input logic [TT_BITS-1:0] tt, input int n, output bit hit, output int k);
        hit = 0;
        k   = 0;
        for (int i = 0; i < n; i++) begin
            if (!hit && tbl[i][47:8] == tt) begin
                hit = 1;
                k   = i;
            end
        end
    endfunction

    typedef struct {
        logic [TT_BITS-1:0] tt;
        int                 hold;
        bit                 early;
        bit                 hit;
        int                 first;
        int                 cnt;
        int                 acc_rr;
        int                 acc_norr;
        int                 lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit         m_hit;
        int         m_k, n, e_acc, e_first, e_cnt;
        logic [TT_BITS-1:0] tt;

        req_valid = 1'b0; resp_ready = 1'b0; req_task_type = '0; num_acc_types = 5'd3;
        for (int i = 0; i < 16; i++) begin
            tbl[i]  = '0;
            rr_m[i] = 0;
        end
        tbl[0] = mk(40'h10, 0, 1);
        tbl[1] = mk(40'h20, 2, 0);
        tbl[2] = mk(40'h30, 3, 3);

        vecs.push_back('{40'h10, 0, 0, 1, 0, 1, 0, 0, 3});
        vecs.push_back('{40'h10, 2, 0, 1, 0, 1, 1, 0, 3});
        vecs.push_back('{40'h20, 0, 0, 1, 2, 0, 2, 2, 5});
        vecs.push_back('{40'h20, 1, 0, 1, 2, 0, 2, 2, 5});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 3, 3, 7});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 4, 3, 7});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 5, 3, 7});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 6, 3, 7});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 3, 3, 7});
        vecs.push_back('{40'h99, 0, 0, 0, 0, 0, 0, 0, 7});
        vecs.push_back('{40'h30, 5, 1, 1, 3, 3, 4, 3, 7});
        vecs.push_back('{40'h30, 0, 0, 1, 3, 3, 5, 3, 7});
        vecs.push_back('{40'h10, 0, 0, 1, 0, 1, 0, 0, 3});

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_portb_en", portb_en, 0);
        chk("rst_portb_addr", portb_addr, 0);
        chk("rst_resp_acc_id", resp_acc_id, 0);
        rstn = 1'b1;

        foreach (vecs[i]) begin
`ifdef SCHED_LOOKUP_RR_EN
            e_acc = vecs[i].acc_rr;
`else
            e_acc = vecs[i].acc_norr;
`endif
            run_and_check(vecs[i].tt, vecs[i].hold, vecs[i].early, vecs[i].hit,
                          vecs[i].first, vecs[i].cnt, e_acc, vecs[i].lat);
        end

        // Last-entry boundary: 0x30 lives just past the valid range
        num_acc_types = 5'd2;
        run_and_check(40'h30, 0, 0, 0, 0, 0, 0, 5);
        num_acc_types = 5'd0;
        run_and_check(40'h10, 1, 0, 0, 0, 0, 0, 1);
        num_acc_types = 5'd3;

        // Reset while comparing entry 1 of a scan for 0x30; rr[0] is 1 at this point in RR builds
        @(negedge clk);
        req_valid = 1'b1; req_task_type = 40'h30;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_addr", portb_addr, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_hit", resp_hit, 0);
        chk("mid_rst_first_id", resp_first_id, 0);
        chk("mid_rst_count", resp_count, 0);
        chk("mid_rst_portb_en", portb_en, 0);
        chk("mid_rst_portb_addr", portb_addr, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) rr_m[i] = 0;
        run_and_check(40'h10, 0, 0, 1, 0, 1, 0, 3);
        rr_m[0] = 1;

        // Randomized table and lookups against the scan model
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(40'h100 + 40'($urandom_range(0, 5)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)));
        for (int it = 0; it < 60; it++) begin
            n  = int'($urandom_range(0, 16));
            tt = 40'h100 + 40'($urandom_range(0, 7));
            num_acc_types = 5'(n);
            model(tt, n, m_hit, m_k);
            e_acc = 0; e_first = 0; e_cnt = 0;
            if (m_hit) begin
                e_first = int'(tbl[m_k][7:4]);
                e_cnt   = int'(tbl[m_k][3:0]);
`ifdef SCHED_LOOKUP_RR_EN
                e_acc   = (e_first + rr_m[m_k]) % 16;
`else
                e_acc   = e_first;
`endif
            end
            run_and_check(tt, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), m_hit,
                          e_first, e_cnt, e_acc, m_hit ? 3 + 2 * m_k : 1 + 2 * n);
            if (m_hit) rr_m[m_k] = (rr_m[m_k] == e_cnt) ? 0 : (rr_m[m_k] + 1) % 16;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
